// File: rtl/tc_pkg.sv
// Shared definitions for the countdown timer: FSM states, register map,
// CTRL bit layout and mode encodings.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tcState_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

    // Modes 10 and 11 fall back to one-shot behaviour.
    function automatic logic isAutoReload(input logic [1:0] mode);
        return mode == MODE_AUTORELOAD;
    endfunction

endpackage

// File: rtl/tc_csr.sv
// Timer register file: CTRL and PRESET storage, write decode and the
// combinational read mux (COUNT is supplied by the counter).
module tc_csr
    import tc_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  regSel_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic        clearEnable_i,
    input  logic [31:0] count_i,
    output logic [31:0] rdata_o,
    output logic [31:0] preset_o,
    output logic        enable_o,
    output logic        autoReload_o,
    output logic        irqMask_o,
    output logic        ctrlWrite_o
);

    logic        enable_q;
    logic [1:0]  mode_q;
    logic        irqMask_q;
    logic [31:0] preset_q;
    logic        presetWrite;

    assign ctrlWrite_o = we_i && (regSel_i == REG_CTRL);
    assign presetWrite = we_i && (regSel_i == REG_PRESET);

    // A bus write to CTRL overrides the FSM's one-shot Enable clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enable_q  <= 1'b0;
            mode_q    <= MODE_ONESHOT;
            irqMask_q <= 1'b0;
            preset_q  <= RESET_PRESET;
        end else begin
            if (ctrlWrite_o) begin
                enable_q  <= wdata_i[CTRL_EN_BIT];
                mode_q    <= wdata_i[CTRL_MODE_MSB:CTRL_MODE_LSB];
                irqMask_q <= wdata_i[CTRL_IM_BIT];
            end else if (clearEnable_i) begin
                enable_q <= 1'b0;
            end
            if (presetWrite) begin
                preset_q <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (regSel_i)
            REG_CTRL:   rdata_o = {28'h0, irqMask_q, mode_q, enable_q};
            REG_PRESET: rdata_o = preset_q;
            REG_COUNT:  rdata_o = count_i;
            default:    rdata_o = 32'h0;
        endcase
    end

    assign preset_o     = preset_q;
    assign enable_o     = enable_q;
    assign autoReload_o = isAutoReload(mode_q);
    assign irqMask_o    = irqMask_q;

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: IDLE/LOAD/CNT/INT sequencer driving a
// 32-bit down counter and a maskable interrupt flag.
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tcState_e    state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        irqFlag_q, irqFlag_d;
    logic        clearEnable;
    logic        enable;
    logic        autoReload;
    logic        irqMask;
    logic        ctrlWrite;
    logic [31:0] preset;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^{Addr[31:4], Addr[1:0]};

    tc_csr #(
        .RESET_PRESET(RESET_PRESET)
    ) u_csr (
        .clk          (clk),
        .reset        (reset),
        .regSel_i     (Addr[3:2]),
        .we_i         (WE),
        .wdata_i      (Din),
        .clearEnable_i(clearEnable),
        .count_i      (count_q),
        .rdata_o      (Dout),
        .preset_o     (preset),
        .enable_o     (enable),
        .autoReload_o (autoReload),
        .irqMask_o    (irqMask),
        .ctrlWrite_o  (ctrlWrite)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 32'h0;
            irqFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            irqFlag_q <= irqFlag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = LOAD;
            LOAD:    state_d = CNT;
            CNT: begin
                if (!enable)                state_d = IDLE;
                else if (count_q > 32'd1)   state_d = CNT;
                else                        state_d = INT;
            end
            INT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A PRESET of 0 is loaded as 1 so the count never has to wrap.
    always_comb begin
        count_d     = count_q;
        irqFlag_d   = irqFlag_q;
        clearEnable = 1'b0;
        case (state_q)
            IDLE: if (enable) irqFlag_d = 1'b0;
            LOAD: count_d = (preset == 32'h0) ? 32'd1 : preset;
            CNT: begin
                if (enable) begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d   = 32'h0;
                        irqFlag_d = 1'b1;
                    end
                end
            end
            INT: begin
                if (autoReload) irqFlag_d   = 1'b0;
                else            clearEnable = 1'b1;
            end
            default: ;
        endcase
        if (ctrlWrite) irqFlag_d = 1'b0;
    end

    assign IRQ = irqFlag_q & irqMask;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations are queued as stimulus is
// driven and popped against IRQ / read data as the timer responds.
module tb_timer_counter;

    localparam logic [31:0] TB_RESET_PRESET = 32'h0000_0007;
    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [31:0] Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t     sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        found;

    timer_counter #(
        .RESET_PRESET(TB_RESET_PRESET)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] din);
        WE   = we;
        Addr = addr;
        Din  = din;
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data);
        tick();
        applyStimulus(1'b0, A_COUNT, 32'h0);
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        Addr = addr;
        #1;
        data = Dout;
    endtask

    function automatic void pushExpect(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        sbq.push_back(e);
    endfunction

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed 0x%h expected none", observed);
        end else begin
            e = sbq.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed 0x%h expected 0x%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic expectReg(input string tag, input logic [31:0] addr, input logic [31:0] value);
        logic [31:0] d;
        pushExpect(tag, value);
        peek(addr, d);
        checkOutput(d);
    endtask

    task automatic expectIrq(input string tag, input logic value);
        pushExpect(tag, {31'b0, value});
        checkOutput({31'b0, IRQ});
    endtask

    initial begin
        int n;

        // Reset state
        reset = 1'b0;
        applyStimulus(1'b0, A_CTRL, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        expectReg("reset_ctrl", A_CTRL, 32'h0);
        expectReg("reset_preset", A_PRESET, TB_RESET_PRESET);
        expectReg("reset_count", A_COUNT, 32'h0);
        expectReg("reset_reserved", A_RSVD, 32'h0);
        expectIrq("reset_irq", 1'b0);
        $display("[TB] reset checks done");

        // One-shot, PRESET=3
        n = 3;
        writeReg(A_PRESET, 32'(n));
        applyStimulus(1'b1, A_CTRL, 32'h9);
        for (int k = 0; k <= 7; k++) begin
            pushExpect($sformatf("oneshot_irq_E%0d", k), (k >= n + 2) ? 32'd1 : 32'd0);
            pushExpect($sformatf("oneshot_count_E%0d", k),
                       (k < 2) ? 32'd0 : (k <= n + 1) ? 32'(n + 2 - k) : 32'd0);
        end
        for (int k = 0; k <= 7; k++) begin
            tick();
            if (k == 0) applyStimulus(1'b0, A_COUNT, 32'h0);
            checkOutput({31'b0, IRQ});
            peek(A_COUNT, rd);
            checkOutput(rd);
        end
        expectReg("oneshot_ctrl_enable_cleared", A_CTRL, 32'h8);
        writeReg(A_CTRL, 32'h8);
        expectIrq("oneshot_irq_cleared_by_ctrl_write", 1'b0);
        $display("[TB] one-shot checks done");

        // Auto-reload, PRESET=2
        n = 2;
        writeReg(A_PRESET, 32'(n));
        applyStimulus(1'b1, A_CTRL, 32'hB);
        for (int k = 0; k <= 8; k++) begin
            pushExpect($sformatf("reload_irq_E%0d", k), (k == n + 2) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= n + 3)
                pushExpect($sformatf("reload_count_E%0d", k), (k <= n + 1) ? 32'(n + 2 - k) : 32'd0);
        end
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) applyStimulus(1'b0, A_COUNT, 32'h0);
            checkOutput({31'b0, IRQ});
            if (k >= 2 && k <= n + 3) begin
                peek(A_COUNT, rd);
                checkOutput(rd);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            if (IRQ) found = 1'b1;
        end
        pushExpect("reload_second_pulse_seen", 32'd1);
        checkOutput({31'b0, found});
        tick();
        expectIrq("reload_second_pulse_width", 1'b0);
        expectReg("reload_ctrl_enable_kept", A_CTRL, 32'hB);
        writeReg(A_CTRL, 32'h0);
        repeat (4) tick();
        $display("[TB] auto-reload checks done");

        // Masked auto-reload, then pause and resume
        n = 8;
        writeReg(A_PRESET, 32'(n));
        applyStimulus(1'b1, A_CTRL, 32'h3);
        for (int k = 0; k <= 10; k++) begin
            pushExpect($sformatf("mask_irq_E%0d", k), 32'd0);
            if (k >= 2)
                pushExpect($sformatf("mask_count_E%0d", k), (k <= n + 1) ? 32'(n + 2 - k) : 32'd0);
        end
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 0) applyStimulus(1'b0, A_COUNT, 32'h0);
            checkOutput({31'b0, IRQ});
            if (k >= 2) begin
                peek(A_COUNT, rd);
                checkOutput(rd);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            peek(A_COUNT, rd);
            if (rd == 32'(n)) found = 1'b1;
        end
        pushExpect("mask_reload_seen", 32'd1);
        checkOutput({31'b0, found});
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            peek(A_COUNT, rd);
            if (rd == 32'd6) found = 1'b1;
        end
        pushExpect("mask_count_reached_6", 32'd1);
        checkOutput({31'b0, found});
        writeReg(A_CTRL, 32'h2);
        for (int j = 0; j < 4; j++) begin
            pushExpect($sformatf("pause_count_%0d", j), 32'd5);
            pushExpect($sformatf("pause_irq_%0d", j), 32'd0);
        end
        for (int j = 0; j < 4; j++) begin
            peek(A_COUNT, rd);
            checkOutput(rd);
            checkOutput({31'b0, IRQ});
            tick();
        end
        expectReg("pause_ctrl", A_CTRL, 32'h2);
        applyStimulus(1'b1, A_CTRL, 32'h3);
        for (int k = 0; k <= 3; k++)
            pushExpect($sformatf("resume_count_E%0d", k),
                       (k < 2) ? 32'd5 : 32'(n + 2 - k));
        for (int k = 0; k <= 3; k++) begin
            tick();
            if (k == 0) applyStimulus(1'b0, A_COUNT, 32'h0);
            peek(A_COUNT, rd);
            checkOutput(rd);
        end
        writeReg(A_CTRL, 32'h0);
        repeat (4) tick();
        $display("[TB] mask/pause checks done");

        // PRESET=0 behaves as 1, using TC1 aliases
        writeReg(32'h0000_7F14, 32'h0);
        applyStimulus(1'b1, 32'h0000_7F10, 32'h9);
        for (int k = 0; k <= 4; k++)
            pushExpect($sformatf("preset0_irq_E%0d", k), (k >= 3) ? 32'd1 : 32'd0);
        for (int k = 0; k <= 4; k++) begin
            tick();
            if (k == 0) applyStimulus(1'b0, A_COUNT, 32'h0);
            checkOutput({31'b0, IRQ});
        end
        writeReg(32'h0000_7F10, 32'h0);
        expectIrq("preset0_irq_cleared", 1'b0);
        $display("[TB] preset-zero checks done");

        // Ignored writes and CTRL upper bits
        writeReg(A_PRESET, 32'h55);
        writeReg(A_COUNT, 32'h1234);
        expectReg("count_write_ignored", A_COUNT, 32'h0);
        writeReg(A_RSVD, 32'hFFFF_FFFF);
        expectReg("reserved_reads_zero", A_RSVD, 32'h0);
        expectReg("reserved_write_no_ctrl_alias", A_CTRL, 32'h0);
        expectReg("reserved_write_no_preset_alias", A_PRESET, 32'h55);
        writeReg(A_CTRL, 32'hFFFF_FFF6);
        expectReg("ctrl_upper_bits_read_zero", A_CTRL, 32'h6);
        writeReg(A_CTRL, 32'h0);

        // Reset in the middle of a count
        writeReg(A_PRESET, 32'd20);
        writeReg(A_CTRL, 32'hB);
        repeat (6) tick();
        reset = 1'b0;
        tick();
        expectReg("midreset_ctrl", A_CTRL, 32'h0);
        expectReg("midreset_preset", A_PRESET, TB_RESET_PRESET);
        expectReg("midreset_count", A_COUNT, 32'h0);
        expectIrq("midreset_irq", 1'b0);
        reset = 1'b1;
        repeat (2) tick();
        expectReg("postreset_count_idle", A_COUNT, 32'h0);
        expectReg("postreset_ctrl", A_CTRL, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
